aes_key_gen: RTL and testbench

AES-128 key-expansion engine. It produces one 128-bit round key per enabled clock.
- Holds the current round key in a register.
- Exports the rotated last word to an external S-box and takes the substituted word back.
- Exports a round index to an external Rcon source.
- Sits beside the AES round datapath and feeds key_o to the AddRoundKey stage.

---
 rtl/aes_key_gen.sv | 77 +++++++
 tb/tb_aes_key_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_gen.sv
// AES-128 key expansion: one round key per enabled clock, with an external S-box and Rcon loop.
// Define AES_KEY_GEN_INT_RCON_EN to use the internal Rcon ROM in place of r_con_i.
module aes_key_gen #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         gen_key,
    input  logic         next_rnd,
    input  logic [127:0] key_i,
    input  logic [7:0]   r_con_i,
    input  logic [31:0]  Sub_i,
    output logic [7:0]   r_con_ctrl,
    output logic [31:0]  Sub_o,
    output logic [127:0] key_o
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    logic [127:0] key_q;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [31:0]  w0n, w1n, w2n, w3n;

`ifdef AES_KEY_GEN_INT_RCON_EN
    logic unused_r_con_i;
    assign unused_r_con_i = ^r_con_i;

    always_comb begin
        rcon = 8'h00;
        case (cnt)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end
`else
    assign rcon = r_con_i;
`endif

    // Each new word chains off the previously computed new word, not the old one.
    always_comb begin
        w0n = key_q[127:96] ^ Sub_i ^ {rcon, 24'h000000};
        w1n = key_q[95:64]  ^ w0n;
        w2n = key_q[63:32]  ^ w1n;
        w3n = key_q[31:0]   ^ w2n;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            key_q <= '0;
            cnt   <= '0;
        end else if (en) begin
            if (gen_key || !next_rnd) begin
                key_q <= key_i;
                cnt   <= '0;
            end else if (cnt < LAST_RND) begin
                key_q <= {w0n, w1n, w2n, w3n};
                cnt   <= cnt + 4'd1;
            end
        end
    end

    assign Sub_o      = {key_q[23:0], key_q[31:24]};
    assign r_con_ctrl = {4'h0, cnt + 4'd1};
    assign key_o      = key_q;

endmodule

// File: tb/tb_aes_key_gen.sv
// Table-driven bench for aes_key_gen with behavioural S-box/Rcon and a scoreboard queue.
`timescale 1ns/1ps
module tb_aes_key_gen;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         gen_key;
    logic         next_rnd;
    logic [127:0] key_i;
    logic [7:0]   r_con_i;
    logic [31:0]  sub_i;
    logic [7:0]   r_con_ctrl;
    logic [31:0]  sub_o;
    logic [127:0] key_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   rcon_tab [16];
    logic [127:0] exp_q [$];
    logic [127:0] m_key;
    logic [3:0]   m_cnt;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        bit           en;
        bit           gen;
        bit           nr;
        logic [127:0] key;
        bit           has_ref;
        logic [127:0] ref_key;
        logic [7:0]   ref_ctrl;
    } vec_t;

    vec_t vecs [$];

    aes_key_gen #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .gen_key    (gen_key),
        .next_rnd   (next_rnd),
        .key_i      (key_i),
        .r_con_i    (r_con_i),
        .Sub_i      (sub_i),
        .r_con_ctrl (r_con_ctrl),
        .Sub_o      (sub_o),
        .key_o      (key_o)
    );

    always #5 clk = ~clk;

    // External S-box and Rcon source, both combinational.
    assign sub_i = {sbox[sub_o[31:24]], sbox[sub_o[23:16]], sbox[sub_o[15:8]], sbox[sub_o[7:0]]};
`ifdef AES_KEY_GEN_INT_RCON_EN
    assign r_con_i = 8'hff;
`else
    assign r_con_i = rcon_tab[r_con_ctrl[3:0]];
`endif

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00)
            for (int x = 1; x < 256; x++)
                if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] a, b, c, d;
        a = k[127:96] ^ subword({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle, update the model, push the expected key and compare after the edge.
    task automatic step(input bit e, input bit g, input bit n, input logic [127:0] k);
        logic [127:0] exp;
        @(negedge clk);
        en = e; gen_key = g; next_rnd = n; key_i = k;
        if (e) begin
            if (g || !n) begin
                m_key = k;
                m_cnt = 4'd0;
            end else if (m_cnt < 4'd10) begin
                m_key = model_next(m_key, rcon_tab[m_cnt + 4'd1]);
                m_cnt = m_cnt + 4'd1;
            end
        end
        exp_q.push_back(m_key);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk("key_o", key_o, exp);
        chk("sub_o", {96'h0, sub_o}, {96'h0, m_key[23:0], m_key[31:24]});
        chk("r_con_ctrl", {120'h0, r_con_ctrl}, {120'h0, 4'h0, m_cnt + 4'd1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rc;
        for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
        for (int i = 0; i < 16; i++) rcon_tab[i] = 8'h00;
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rcon_tab[i] = rc;
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        end

        nrst = 1'b1; en = 1'b0; gen_key = 1'b0; next_rnd = 1'b0; key_i = '0;
        m_key = '0; m_cnt = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", key_o, '0);
        chk("rst_sub", {96'h0, sub_o}, '0);
        chk("rst_ctrl", {120'h0, r_con_ctrl}, 128'h01);
        @(negedge clk);
        nrst = 1'b0;

        vecs.push_back('{1, 0, 0, K1, 1, K1, 8'h01});
        vecs.push_back('{1, 0, 1, K2, 1, R1, 8'h02});
        vecs.push_back('{1, 0, 1, K2, 1, R2, 8'h03});
        vecs.push_back('{1, 0, 1, K2, 0, '0, 8'h00});
        vecs.push_back('{0, 0, 1, K2, 0, '0, 8'h00});
        vecs.push_back('{0, 0, 1, K2, 0, '0, 8'h00});
        vecs.push_back('{0, 1, 1, K2, 0, '0, 8'h00});
        for (int i = 4; i <= 9; i++) vecs.push_back('{1, 0, 1, K2, 0, '0, 8'h00});
        vecs.push_back('{1, 0, 1, K2, 1, R10, 8'h0b});
        vecs.push_back('{1, 0, 1, K2, 1, R10, 8'h0b});
        vecs.push_back('{1, 0, 1, K2, 1, R10, 8'h0b});
        vecs.push_back('{1, 0, 0, K1, 1, K1, 8'h01});
        for (int i = 1; i <= 5; i++) vecs.push_back('{1, 0, 1, K1, 0, '0, 8'h00});
        vecs.push_back('{1, 1, 1, K2, 1, K2, 8'h01});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].gen, vecs[i].nr, vecs[i].key);
            if (vecs[i].has_ref) begin
                chk($sformatf("vec%0d_key", i), key_o, vecs[i].ref_key);
                chk($sformatf("vec%0d_ctrl", i), {120'h0, r_con_ctrl}, {120'h0, vecs[i].ref_ctrl});
            end
            if (i == 0) chk("load_sub", {96'h0, sub_o}, {96'h0, 32'hcf4f3c09});
        end

        // Asynchronous reset mid-cycle, mid-expansion.
        step(1, 0, 0, K1);
        repeat (3) step(1, 0, 1, K1);
        @(posedge clk);
        #3;
        nrst = 1'b1;
        #1;
        m_key = '0; m_cnt = 4'd0;
        chk("async_rst_key", key_o, '0);
        chk("async_rst_sub", {96'h0, sub_o}, '0);
        chk("async_rst_ctrl", {120'h0, r_con_ctrl}, 128'h01);
        @(negedge clk);
        nrst = 1'b0;
        step(1, 0, 0, K1);
        step(1, 0, 1, K1);
        chk("restart_r1", key_o, R1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
